// File: rtl/verifier_sumcheck_rounds_pkg.sv
// Shared field parameters, FSM state encoding and the modular multiply-add helper
// used by the sumcheck round checker.
package verifier_sumcheck_rounds_pkg;

    localparam int F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q = 16'd65521;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUM  = 3'd1,
        ST_CMP  = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // (a*b + c) mod q; operands are assumed already reduced into [0,q).
    function automatic logic [F_NBITS-1:0] fmul_add(input logic [F_NBITS-1:0] a,
                                                    input logic [F_NBITS-1:0] b,
                                                    input logic [F_NBITS-1:0] c);
        logic [2*F_NBITS-1:0] prod;
        logic [2*F_NBITS:0]   wide;
        logic [2*F_NBITS:0]   rem;
        prod = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        wide = {1'b0, prod} + {{(F_NBITS+1){1'b0}}, c};
        rem  = wide % {{(F_NBITS+1){1'b0}}, F_Q};
        return rem[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_sumcheck_rounds_mul_add.sv
// Shared field unit: res = a*r + c mod q, one op per en pulse, done one cycle later.
// The round checker uses it with r=1 as a plain modular adder.
module field_mul_add
    import verifier_sumcheck_rounds_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a_in,
    input  logic [F_NBITS-1:0] r_in,
    input  logic [F_NBITS-1:0] c_in,
    output logic [F_NBITS-1:0] res_out,
    output logic               done
);

    logic [F_NBITS-1:0] res_d, res_q;
    logic               done_d, done_q;

    // Compute the next result only when an op is issued; done is a single-cycle pulse.
    always_comb begin
        res_d  = res_q;
        done_d = 1'b0;
        if (en) begin
            res_d  = fmul_add(a_in, r_in, c_in);
            done_d = 1'b1;
        end else begin
            res_d  = res_q;
        end
    end

    // Result and done registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            done_q <= done_d;
        end
    end

    assign res_out = res_q;
    assign done    = done_q;

endmodule

// File: rtl/verifier_sumcheck_rounds.sv
// Multi-channel sumcheck round checker: per channel checks c(0)+c(1) against the held
// claim, then Horner-evaluates c(r) as the next claim, sharing one field_mul_add unit.
module verifier_sumcheck_rounds
    import verifier_sumcheck_rounds_pkg::*;
#(
    parameter int nChannels = 2,
    parameter int nDegree   = 2,
    parameter int nRounds   = 3
) (
    input  logic                                       clk,
    input  logic                                       rstb,
    input  logic                                       en,
    input  logic                                       restart,
    input  logic [F_NBITS*(nDegree+1)*nChannels-1:0]   c_in,
    input  logic [F_NBITS-1:0]                         r_in,
    input  logic [F_NBITS*nChannels-1:0]               claim_in,
    output logic [F_NBITS*nChannels-1:0]               claim_out,
    output logic [nChannels-1:0]                       ok,
    output logic                                       ready,
    output logic                                       fin
);

    localparam int NCOEFFS = nDegree + 1;
    localparam int CBUS_W  = F_NBITS * NCOEFFS * nChannels;
    localparam int CLM_W   = F_NBITS * nChannels;
    localparam int CH_W    = (nChannels > 1) ? $clog2(nChannels) : 1;
    localparam int IDX_W   = (NCOEFFS > 1) ? $clog2(NCOEFFS) : 1;
    localparam int RND_W   = (nRounds > 0) ? $clog2(nRounds + 1) : 1;
    localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(nChannels - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(nDegree);
    localparam logic [IDX_W-1:0]   IDX_TOP  = IDX_W'(nDegree - 1);
    localparam logic [RND_W-1:0]   RND_LAST = RND_W'(nRounds);
    localparam logic [F_NBITS-1:0] ONE      = F_NBITS'(1);

    function automatic logic [F_NBITS-1:0] coef_at(input logic [CBUS_W-1:0] bus,
                                                   input int ch, input int idx);
        return bus[(ch*NCOEFFS + idx)*F_NBITS +: F_NBITS];
    endfunction

    function automatic logic [F_NBITS-1:0] claim_at(input logic [CLM_W-1:0] bus, input int ch);
        return bus[ch*F_NBITS +: F_NBITS];
    endfunction

    state_e              state_d, state_q;
    logic [CH_W-1:0]     ch_d, ch_q;
    logic [IDX_W-1:0]    idx_d, idx_q;
    logic [RND_W-1:0]    round_d, round_q;
    logic                fin_d, fin_q;
    logic                ready_d, ready_q;
    logic                pend_d, pend_q;
    logic [nChannels-1:0] ok_d, ok_q;
    logic [CLM_W-1:0]    claim_d, claim_q;
    logic [CBUS_W-1:0]   coef_d, coef_q;
    logic [F_NBITS-1:0]  r_d, r_q;
    logic [F_NBITS-1:0]  acc_d, acc_q;

    logic                mac_en_s;
    logic [F_NBITS-1:0]  mac_r_s;
    logic [F_NBITS-1:0]  mac_c_s;
    logic [F_NBITS-1:0]  mac_res_s;
    logic                mac_done_s;

    field_mul_add u_mac (
        .clk     (clk),
        .rstb    (rstb),
        .en      (mac_en_s),
        .a_in    (acc_q),
        .r_in    (mac_r_s),
        .c_in    (mac_c_s),
        .res_out (mac_res_s),
        .done    (mac_done_s)
    );

    // Round sequencing: each SUM/EVAL step issues one op and waits for its done.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        idx_d    = idx_q;
        round_d  = round_q;
        fin_d    = fin_q;
        ready_d  = ready_q;
        pend_d   = pend_q;
        ok_d     = ok_q;
        claim_d  = claim_q;
        coef_d   = coef_q;
        r_d      = r_q;
        acc_d    = acc_q;
        mac_en_s = 1'b0;
        mac_r_s  = ONE;
        mac_c_s  = coef_at(coef_q, int'(ch_q), int'(idx_q));

        case (state_q)
            ST_IDLE: begin
                // A plain en after fin is dropped; only a restart begins a new trip.
                if (en && (restart || !fin_q)) begin
                    coef_d  = c_in;
                    r_d     = r_in;
                    ch_d    = '0;
                    idx_d   = '0;
                    acc_d   = coef_at(c_in, 0, 0);
                    pend_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_SUM;
                    if (restart) begin
                        claim_d = claim_in;
                        round_d = '0;
                        ok_d    = '1;
                        fin_d   = 1'b0;
                    end else begin
                        claim_d = claim_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SUM: begin
                // acc starts at c0, then c0..cD are added in turn: 2*c0 + c1 + ... + cD.
                if (!pend_q) begin
                    mac_en_s = 1'b1;
                    pend_d   = 1'b1;
                end else if (mac_done_s) begin
                    pend_d = 1'b0;
                    acc_d  = mac_res_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_CMP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    pend_d = 1'b1;
                end
            end
            ST_CMP: begin
                ok_d[ch_q] = ok_q[ch_q] & (acc_q == claim_at(claim_q, int'(ch_q)));
                acc_d      = coef_at(coef_q, int'(ch_q), nDegree);
                idx_d      = IDX_TOP;
                pend_d     = 1'b0;
                state_d    = ST_EVAL;
            end
            ST_EVAL: begin
                mac_r_s = r_q;
                if (!pend_q) begin
                    mac_en_s = 1'b1;
                    pend_d   = 1'b1;
                end else if (mac_done_s) begin
                    pend_d = 1'b0;
                    acc_d  = mac_res_s;
                    if (idx_q == '0) begin
                        claim_d[int'(ch_q)*F_NBITS +: F_NBITS] = mac_res_s;
                        if (ch_q == CH_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            ch_d    = ch_q + CH_W'(1);
                            idx_d   = '0;
                            acc_d   = coef_at(coef_q, int'(ch_q) + 1, 0);
                            state_d = ST_SUM;
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    pend_d = 1'b1;
                end
            end
            ST_DONE: begin
                round_d = round_q + RND_W'(1);
                fin_d   = ((round_q + RND_W'(1)) == RND_LAST);
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any round in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            idx_q   <= '0;
            round_q <= '0;
            fin_q   <= 1'b0;
            ready_q <= 1'b1;
            pend_q  <= 1'b0;
            ok_q    <= '1;
            claim_q <= '0;
            coef_q  <= '0;
            r_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            fin_q   <= fin_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
            ok_q    <= ok_d;
            claim_q <= claim_d;
            coef_q  <= coef_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
        end
    end

    assign claim_out = claim_q;
    assign ok        = ok_q;
    assign ready     = ready_q;
    assign fin       = fin_q;

endmodule
